// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and width constants for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 64;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned MASK_W_DEF = DATA_W_DEF / 8;

    // Wide enough for STARVE_LIMIT up to 15 and TIMEOUT up to 255.
    localparam int unsigned STARVE_W  = 4;
    localparam int unsigned TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic int unsigned mask_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_starve_guard.sv
// Data-over-fetch priority with a saturating counter that forces a fetch grant
// after STARVE_LIMIT consecutive data wins while fetch was waiting.
module arb_starve_guard
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_req,
    input  logic d_req,
    input  logic arbitrate,
    output logic grant_i
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    assign grant_i = i_req && (!d_req || (starve_cnt == LIMIT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (arbitrate) begin
            if (grant_i || !i_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one variable-latency memory port between
// instruction fetch and load/store, with a timeout that turns a hung access into an error.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_ack_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    output logic                i_err_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_wmask_i,
    output logic                d_ack_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    arb_state_t           state_q;
    arb_state_t           state_d;
    owner_t               owner;
    logic [TIMEOUT_W-1:0] tcnt_q;
    logic                 arbitrate;
    logic                 grant_i;
    logic                 done_ack;
    logic                 done_to;

    arb_starve_guard #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_guard (
        .clock    (clock),
        .reset    (reset),
        .i_req    (i_req_i),
        .d_req    (d_req_i),
        .arbitrate(arbitrate),
        .grant_i  (grant_i)
    );

    assign owner = (state_q == BUSY_I) ? OWN_I : OWN_D;

    always_comb begin
        state_d   = state_q;
        arbitrate = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    arbitrate = 1'b1;
                    state_d   = grant_i ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack in the final counted cycle still beats the timeout.
                if (mem_ack_i) begin
                    done_ack = 1'b1;
                    state_d  = RESP;
                end else if (tcnt_q == TO_LAST) begin
                    done_to = 1'b1;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tcnt_q      <= '0;
            busy_o      <= 1'b0;
            i_ack_o     <= 1'b0;
            i_rdata_o   <= '0;
            i_err_o     <= 1'b0;
            d_ack_o     <= 1'b0;
            d_rdata_o   <= '0;
            d_err_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
        end else begin
            i_ack_o <= 1'b0;
            d_ack_o <= 1'b0;
            busy_o  <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (arbitrate) begin
                        mem_req_o <= 1'b1;
                        if (grant_i) begin
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= i_addr_i;
                            mem_wdata_o <= '0;
                            mem_wmask_o <= '0;
                        end else begin
                            mem_we_o    <= d_we_i;
                            mem_addr_o  <= d_addr_i;
                            mem_wdata_o <= d_wdata_i;
                            mem_wmask_o <= d_we_i ? d_wmask_i : '0;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    tcnt_q <= tcnt_q + TIMEOUT_W'(1);
                    if (done_ack || done_to) begin
                        mem_req_o <= 1'b0;
                        if (owner == OWN_I) begin
                            i_ack_o   <= 1'b1;
                            i_rdata_o <= done_ack ? mem_rdata_i : '0;
                            i_err_o   <= done_to;
                        end else begin
                            d_ack_o   <= 1'b1;
                            d_rdata_o <= done_ack ? mem_rdata_i : '0;
                            d_err_o   <= done_to;
                        end
                    end
                end
                default: tcnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory commands and responses; independent monitors compare what the DUT presents.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W       = 64;
    localparam int unsigned DATA_W       = 64;
    localparam int          STARVE_LIMIT = 4;
    localparam int          TIMEOUT      = 255;

    logic              clock;
    logic              reset;
    logic              i_req_i;
    logic [63:0]       i_addr_i;
    logic              i_ack_o;
    logic [63:0]       i_rdata_o;
    logic              i_err_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [63:0]       d_addr_i;
    logic [63:0]       d_wdata_i;
    logic [7:0]        d_wmask_i;
    logic              d_ack_o;
    logic [63:0]       d_rdata_o;
    logic              d_err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [63:0]       mem_addr_o;
    logic [63:0]       mem_wdata_o;
    logic [7:0]        mem_wmask_o;
    logic              mem_ack_i;
    logic [63:0]       mem_rdata_i;
    logic              busy_o;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_ack_o    (i_ack_o),
        .i_rdata_o  (i_rdata_o),
        .i_err_o    (i_err_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_wmask_i  (d_wmask_i),
        .d_ack_o    (d_ack_o),
        .d_rdata_o  (d_rdata_o),
        .d_err_o    (d_err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .busy_o     (busy_o)
    );

    typedef struct {
        int          cyc;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } cmd_t;

    typedef struct {
        int          cyc;
        bit          is_i;
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: who is currently requesting, and the starvation count.
    bit i_pend = 0;
    bit d_pend = 0;
    int starve = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory-side monitor: every new request must match the next predicted command
    // and stay stable until it is dropped.
    cmd_t cur_cmd;
    logic prev_req = 1'b0;
    always @(negedge clock) begin
        if (mem_req_o && !prev_req) begin
            if (cmd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mem_req_unexpected: got mem_req_o=1 expected no request (cycle %0d)", cyc);
            end else begin
                cur_cmd = cmd_q.pop_front();
                chk("mem_req_cycle", 64'(cyc), 64'(cur_cmd.cyc));
            end
        end
        if (mem_req_o) begin
            chk("mem_addr", mem_addr_o, cur_cmd.addr);
            chk("mem_we", 64'(mem_we_o), 64'(cur_cmd.we));
            chk("mem_wmask", 64'(mem_wmask_o), 64'(cur_cmd.mask));
            if (cur_cmd.we) chk("mem_wdata", mem_wdata_o, cur_cmd.wdata);
        end
        prev_req = mem_req_o;
    end

    // Requester-side monitor: every ack pulse must match the next predicted response.
    rsp_t cur_rsp;
    always @(negedge clock) begin
        if (i_ack_o || d_ack_o) begin
            if (i_ack_o && d_ack_o) begin
                total++;
                bad++;
                $display("FAIL both_acks: got i_ack_o=1 d_ack_o=1 expected one (cycle %0d)", cyc);
            end
            if (rsp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected: got i_ack_o=%0b d_ack_o=%0b expected none (cycle %0d)",
                         i_ack_o, d_ack_o, cyc);
            end else begin
                cur_rsp = rsp_q.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(cur_rsp.cyc));
                chk("ack_is_fetch", 64'(i_ack_o), 64'(cur_rsp.is_i));
                if (cur_rsp.is_i) begin
                    chk("i_rdata", i_rdata_o, cur_rsp.rdata);
                    chk("i_err", 64'(i_err_o), 64'(cur_rsp.err));
                end else begin
                    chk("d_rdata", d_rdata_o, cur_rsp.rdata);
                    chk("d_err", 64'(d_err_o), 64'(cur_rsp.err));
                end
            end
        end
    end

    task automatic set_i(input logic [63:0] addr);
        i_pend   = 1;
        i_req_i  = 1'b1;
        i_addr_i = addr;
    endtask

    task automatic set_d(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] mask);
        d_pend    = 1;
        d_req_i   = 1'b1;
        d_we_i    = we;
        d_addr_i  = addr;
        d_wdata_i = wdata;
        d_wmask_i = mask;
    endtask

    task automatic rand_i();
        set_i({$urandom, $urandom});
    endtask

    task automatic rand_d();
        set_d(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
    endtask

    task automatic add_reqs(input int pct);
        if (!i_pend && int'($urandom_range(0, 99)) < pct) rand_i();
        if (!d_pend && int'($urandom_range(0, 99)) < pct) rand_d();
        if (!i_pend && !d_pend) begin
            if ($urandom_range(0, 1) == 1) rand_i();
            else rand_d();
        end
    endtask

    // Called at the falling edge of an IDLE cycle with requests already driven.
    // k = busy cycle in which memory acks (1 = earliest); k = 0 means never ack.
    // Returns at the falling edge of the response cycle with the winner's request dropped.
    task automatic round(input int k, input logic [63:0] rd);
        int   a;
        int   lat;
        bit   win_i;
        cmd_t c;
        rsp_t r;
        a     = cyc;
        win_i = i_pend && (!d_pend || starve == STARVE_LIMIT);
        if (!win_i && i_pend) starve = (starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT;
        else starve = 0;

        c.cyc   = a + 1;
        c.we    = win_i ? 1'b0 : d_we_i;
        c.addr  = win_i ? i_addr_i : d_addr_i;
        c.wdata = d_wdata_i;
        c.mask  = (win_i || !d_we_i) ? 8'h00 : d_wmask_i;
        cmd_q.push_back(c);

        lat     = (k == 0) ? TIMEOUT : k;
        r.cyc   = a + 1 + lat;
        r.is_i  = win_i;
        r.rdata = (k == 0) ? 64'h0 : rd;
        r.err   = (k == 0);
        rsp_q.push_back(r);

        for (int j = 1; j <= lat; j++) begin
            @(negedge clock);
            if (j == k) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = {$urandom, $urandom};
            end
        end
        @(negedge clock);
        mem_ack_i = 1'b0;
        if (win_i) begin
            i_pend  = 0;
            i_req_i = 1'b0;
        end else begin
            d_pend  = 0;
            d_req_i = 1'b0;
        end
    endtask

    initial begin
        reset       = 1'b0;
        i_req_i     = 1'b0;
        i_addr_i    = '0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        d_wmask_i   = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;

        repeat (3) @(negedge clock);
        chk("rst_mem_req", 64'(mem_req_o), 64'h0);
        chk("rst_busy", 64'(busy_o), 64'h0);
        chk("rst_i_ack", 64'(i_ack_o), 64'h0);
        chk("rst_d_ack", 64'(d_ack_o), 64'h0);
        chk("rst_mem_addr", mem_addr_o, 64'h0);
        chk("rst_mem_wmask", 64'(mem_wmask_o), 64'h0);
        chk("rst_i_rdata", i_rdata_o, 64'h0);
        chk("rst_d_err", 64'(d_err_o), 64'h0);
        reset = 1'b1;

        // Spurious memory ack while idle.
        @(negedge clock);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 64'h1234_5678_9abc_def0;
        @(negedge clock);
        mem_ack_i = 1'b0;
        chk("spur_busy", 64'(busy_o), 64'h0);
        chk("spur_mem_req", 64'(mem_req_o), 64'h0);
        chk("spur_i_ack", 64'(i_ack_o), 64'h0);
        chk("spur_d_ack", 64'(d_ack_o), 64'h0);
        @(negedge clock);
        chk("spur_busy2", 64'(busy_o), 64'h0);

        // Single fetch with minimum latency.
        set_i(64'h0000_0000_8000_0000);
        round(1, 64'h0000_0000_0000_0513);

        // Store held for three busy cycles.
        @(negedge clock);
        set_d(1'b1, 64'h1008, 64'h0000_0000_DEAD_BEEF, 8'h0F);
        round(3, {$urandom, $urandom});

        // Load that never gets an ack, then one acked in the last allowed cycle.
        @(negedge clock);
        set_d(1'b0, 64'h2000, 64'h0, 8'hFF);
        round(0, {$urandom, $urandom});
        @(negedge clock);
        set_d(1'b0, 64'h2008, 64'h0, 8'h00);
        round(TIMEOUT, 64'hCAFE_F00D_0000_0001);

        // Both requesters continuously re-requesting.
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            add_reqs(100);
            round(int'($urandom_range(1, 3)), {$urandom, $urandom});
        end

        // Random mix with idle gaps.
        for (int n = 0; n < 80; n++) begin
            @(negedge clock);
            if (!i_pend && !d_pend && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
            add_reqs(50);
            round(int'($urandom_range(1, 5)), {$urandom, $urandom});
        end

        // Drain a request left waiting by the last round.
        while (i_pend || d_pend) begin
            @(negedge clock);
            round(int'($urandom_range(1, 3)), {$urandom, $urandom});
        end

        // Reset while a data access is in flight, then a late memory ack.
        @(negedge clock);
        set_d(1'b1, 64'h3000, 64'h1111_2222_3333_4444, 8'hA5);
        cur_cmd.cyc   = cyc + 1;
        cur_cmd.we    = 1'b1;
        cur_cmd.addr  = 64'h3000;
        cur_cmd.wdata = 64'h1111_2222_3333_4444;
        cur_cmd.mask  = 8'hA5;
        cmd_q.push_back(cur_cmd);
        starve = 0;
        repeat (2) @(negedge clock);
        reset   = 1'b0;
        d_req_i = 1'b0;
        d_pend  = 0;
        @(negedge clock);
        chk("midrst_mem_req", 64'(mem_req_o), 64'h0);
        chk("midrst_busy", 64'(busy_o), 64'h0);
        chk("midrst_d_ack", 64'(d_ack_o), 64'h0);
        reset = 1'b1;
        @(negedge clock);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clock);
        mem_ack_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk("late_ack_busy", 64'(busy_o), 64'h0);
            chk("late_ack_d_ack", 64'(d_ack_o), 64'h0);
            @(negedge clock);
        end

        // Normal operation resumes after the abandoned access.
        set_i(64'h0000_0000_8000_0040);
        round(2, {$urandom, $urandom});

        repeat (4) @(negedge clock);
        chk("cmd_q_left", 64'(cmd_q.size()), 64'h0);
        chk("rsp_q_left", 64'(rsp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
